// File: rtl/priority_sched.sv
// rtl/priority_sched.sv - round-robin one-hot priority scheduler with per-channel slot lengths and override
module priority_sched #(
  parameter  int N_CH = 4,
  parameter  int TW   = 8,
  localparam int IW   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CH*TW-1:0] dur_i,
  input  logic [N_CH-1:0]    req_i,
  input  logic               ovr_valid,
  input  logic [IW-1:0]      ovr_ch,
  output logic [N_CH-1:0]    grant,
  output logic [IW-1:0]      grant_idx,
  output logic               slot_done,
  output logic [TW-1:0]      remaining,
  output logic               in_override
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    OVERRIDE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [N_CH-1:0]    grant_nxt;
  logic [IW-1:0]      grant_idx_nxt;
  logic               slot_done_nxt;
  logic [TW-1:0]      remaining_nxt;
  logic               in_override_nxt;
  logic [TW-1:0]      cnt, cnt_nxt;
  logic [TW-1:0]      dur_lat, dur_lat_nxt;
  logic [IW-1:0]      ptr, ptr_nxt;

  logic [TW-1:0]      dur_arr [N_CH];
  logic               ovr_ok;
  logic [IW-1:0]      base;
  logic [IW:0]        srch;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [TW-1:0]      win_dur;

  // Unpack the flat duration bus into one field per channel
  for (genvar k = 0; k < N_CH; k++) begin : g_dur
    assign dur_arr[k] = dur_i[k*TW +: TW];
  end

  // Channel codes beyond N_CH-1 only exist when N_CH is not a power of two
  if ((1 << IW) == N_CH) begin : g_ovr_pow2
    assign ovr_ok = ovr_valid;
  end else begin : g_ovr_range
    assign ovr_ok = ovr_valid && (ovr_ch < IW'(N_CH));
  end

  // First requesting channel after base, wrapping; base itself is checked last
  function automatic logic [IW:0] search(input logic [IW-1:0] b, input logic [N_CH-1:0] req);
    logic [IW:0]   r;
    logic [IW-1:0] idx;
    int            c;
    r = '0;
    for (int i = N_CH; i >= 1; i--) begin
      c = int'(b) + i;
      if (c >= N_CH) c = c - N_CH;
      idx = c[IW-1:0];
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [IW-1:0] idx);
    return {{(N_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Leaving an override searches from the overridden channel, otherwise from the pointer
  assign base      = (state == OVERRIDE) ? grant_idx : ptr;
  assign srch      = search(base, req_i);
  assign win_found = srch[IW];
  assign win_idx   = srch[IW-1:0];
  assign win_dur   = (dur_arr[win_idx] == '0) ? TW'(1) : dur_arr[win_idx];

  // Register every output and the internal scheduling state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      slot_done   <= 1'b0;
      remaining   <= '0;
      in_override <= 1'b0;
      cnt         <= '0;
      dur_lat     <= '0;
      ptr         <= IW'(N_CH - 1);
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_idx   <= grant_idx_nxt;
      slot_done   <= slot_done_nxt;
      remaining   <= remaining_nxt;
      in_override <= in_override_nxt;
      cnt         <= cnt_nxt;
      dur_lat     <= dur_lat_nxt;
      ptr         <= ptr_nxt;
    end
  end

  // Next-state decision: slot countdown, hand-over, idle fallback, override preemption
  always_comb begin
    logic take;
    logic go_idle;
    state_nxt       = state;
    grant_nxt       = grant;
    grant_idx_nxt   = grant_idx;
    slot_done_nxt   = 1'b0;
    remaining_nxt   = remaining;
    in_override_nxt = in_override;
    cnt_nxt         = cnt;
    dur_lat_nxt     = dur_lat;
    ptr_nxt         = ptr;
    take            = 1'b0;
    go_idle         = 1'b0;

    case (state)
      IDLE: begin
        take = en && win_found;
      end
      RUN: begin
        if (cnt == dur_lat - TW'(1)) begin
          slot_done_nxt = 1'b1;
          take          = en && win_found;
          go_idle       = !take;
        end else begin
          cnt_nxt       = cnt + TW'(1);
          remaining_nxt = dur_lat - TW'(2) - cnt;
        end
      end
      OVERRIDE: begin
        ptr_nxt         = grant_idx;
        in_override_nxt = 1'b0;
        take            = en && win_found;
        go_idle         = !take;
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_nxt     = IDLE;
      grant_nxt     = '0;
      remaining_nxt = '0;
      cnt_nxt       = '0;
    end

    if (take) begin
      state_nxt       = RUN;
      grant_nxt       = onehot(win_idx);
      grant_idx_nxt   = win_idx;
      ptr_nxt         = win_idx;
      cnt_nxt         = '0;
      dur_lat_nxt     = win_dur;
      remaining_nxt   = win_dur - TW'(1);
      in_override_nxt = 1'b0;
    end

    // Override beats everything, including a slot that ends this cycle
    if (ovr_ok) begin
      state_nxt       = OVERRIDE;
      grant_nxt       = onehot(ovr_ch);
      grant_idx_nxt   = ovr_ch;
      slot_done_nxt   = 1'b0;
      remaining_nxt   = '0;
      in_override_nxt = 1'b1;
      cnt_nxt         = '0;
      ptr_nxt         = ptr;
    end
  end

endmodule

// File: tb/tb_priority_sched.sv
// tb/tb_priority_sched.sv - scoreboard bench for priority_sched
module tb_priority_sched;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] dur_i;
  logic [3:0]  req_i;
  logic        ovr_valid;
  logic [1:0]  ovr_ch;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        slot_done;
  logic [7:0]  remaining;
  logic        in_override;

  int total;
  int bad;

  // {grant, grant_idx, slot_done, remaining, in_override}
  logic [15:0] exp_q [$];
  logic [15:0] obs;
  logic [15:0] exp_v;

  priority_sched dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dur_i       (dur_i),
    .req_i       (req_i),
    .ovr_valid   (ovr_valid),
    .ovr_ch      (ovr_ch),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .slot_done   (slot_done),
    .remaining   (remaining),
    .in_override (in_override)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {grant, grant_idx, slot_done, remaining, in_override};

  function automatic logic [15:0] mk(input int g, input int idx, input int sd, input int rem, input int ov);
    logic [3:0] gv;
    logic [1:0] iv;
    logic [7:0] rv;
    gv = g[3:0];
    iv = idx[1:0];
    rv = rem[7:0];
    return {gv, iv, sd[0], rv, ov[0]};
  endfunction

  task automatic push_slot(input int ch, input int d, input bit first);
    for (int k = 0; k < d; k++)
      exp_q.push_back(mk(1 << ch, ch, (k == 0 && !first) ? 1 : 0, d - 1 - k, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    req_i = '0;
    ovr_valid = 1'b0;
    ovr_ch = '0;
    dur_i = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== mk(0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", obs, mk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_rotation();
    int n;
    do_reset();
    en = 1'b1;
    req_i = 4'b1111;
    dur_i = {8'd4, 8'd3, 8'd2, 8'd1};
    push_slot(0, 1, 1);
    push_slot(1, 2, 0);
    push_slot(2, 3, 0);
    push_slot(3, 4, 0);
    push_slot(0, 1, 0);
    push_slot(1, 2, 0);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL rotation cyc=%0d got=%h exp=%h", j, obs, exp_v);
      end
    end
  endtask

  task automatic test_sparse();
    int n;
    do_reset();
    en = 1'b1;
    req_i = 4'b1010;
    dur_i = {8'd5, 8'd5, 8'd5, 8'd5};
    push_slot(1, 5, 1);
    push_slot(3, 5, 0);
    push_slot(1, 5, 0);
    push_slot(3, 5, 0);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL sparse cyc=%0d got=%h exp=%h", j, obs, exp_v);
      end
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    en = 1'b1;
    req_i = 4'b0100;
    dur_i = {8'd3, 8'd3, 8'd3, 8'd3};
    push_slot(2, 3, 1);
    push_slot(2, 3, 0);
    push_slot(2, 3, 0);
    exp_q.push_back(mk(0, 2, 1, 0, 0));
    exp_q.push_back(mk(0, 2, 0, 0, 0));
    exp_q.push_back(mk(0, 2, 0, 0, 0));
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL single cyc=%0d got=%h exp=%h", j, obs, exp_v);
      end
      if (j == 7) req_i = 4'b0000;
    end
  endtask

  task automatic test_override();
    int n;
    do_reset();
    en = 1'b1;
    req_i = 4'b1111;
    dur_i = {8'd3, 8'd3, 8'd4, 8'd2};
    push_slot(0, 2, 1);
    exp_q.push_back(mk(4'b0010, 1, 1, 3, 0));
    exp_q.push_back(mk(4'b0010, 1, 0, 2, 0));
    for (int k = 0; k < 6; k++) exp_q.push_back(mk(4'b1000, 3, 0, 0, 1));
    push_slot(0, 2, 1);
    push_slot(1, 4, 0);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL override cyc=%0d got=%h exp=%h", j, obs, exp_v);
      end
      if (j == 3) begin
        ovr_valid = 1'b1;
        ovr_ch = 2'd3;
      end
      if (j == 9) ovr_valid = 1'b0;
    end
  endtask

  task automatic test_ovr_at_slot_end();
    int n;
    do_reset();
    en = 1'b1;
    req_i = 4'b1111;
    dur_i = {8'd2, 8'd2, 8'd2, 8'd2};
    push_slot(0, 2, 1);
    exp_q.push_back(mk(4'b0100, 2, 0, 0, 1));
    exp_q.push_back(mk(4'b0010, 1, 0, 0, 1));
    push_slot(2, 2, 1);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL ovr_slot_end cyc=%0d got=%h exp=%h", j, obs, exp_v);
      end
      if (j == 1) begin
        ovr_valid = 1'b1;
        ovr_ch = 2'd2;
      end
      if (j == 2) ovr_ch = 2'd1;
      if (j == 3) ovr_valid = 1'b0;
    end
  endtask

  task automatic test_dur_edge();
    int n;
    do_reset();
    en = 1'b1;
    req_i = 4'b0011;
    dur_i = {8'd2, 8'd2, 8'd3, 8'd0};
    push_slot(0, 1, 1);
    push_slot(1, 3, 0);
    push_slot(0, 1, 0);
    push_slot(1, 7, 0);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL dur_edge cyc=%0d got=%h exp=%h", j, obs, exp_v);
      end
      if (j == 1) dur_i = {8'd2, 8'd2, 8'd7, 8'd0};
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    en = 1'b1;
    req_i = 4'b1111;
    dur_i = {8'd3, 8'd3, 8'd3, 8'd3};
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (obs !== mk(0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", obs, mk(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst = 1'b1;
    push_slot(0, 3, 1);
    push_slot(1, 3, 0);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL after_reset cyc=%0d got=%h exp=%h", j, obs, exp_v);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    en = 1'b0;
    req_i = '0;
    dur_i = '0;
    ovr_valid = 1'b0;
    ovr_ch = '0;
    test_reset();
    test_rotation();
    test_sparse();
    test_single();
    test_override();
    test_ovr_at_slot_end();
    test_dur_edge();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
